// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment decode table for the 7-segment path.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark (active-low).
  localparam seg_t SEG_OFF = 7'h7F;

  // Active-low segment pattern {CA,CB,CC,CD,CE,CF,CG} for one hex nibble.
  function automatic seg_t hex2seg(input logic [3:0] nibble);
    seg_t seg;
    case (nibble)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder, shared with the sign/text path.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  // Pure table lookup.
  always_comb begin
    seg_o = hex2seg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit common-anode 7-segment scanner with frame-synchronous
// double buffering, per-slot blanking and leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int NUM_DIGITS   = 8
)
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_value,
  input  logic [7:0]  i_dp,
  input  logic [7:0]  i_en,
  input  logic        i_lzb,
  input  logic        i_load,
  output logic        o_pending,
  output logic        o_frame_tick,
  output logic [7:0]  o_an,
  output seg_t        o_seg,
  output logic        o_dp
);

  localparam int PRESCALE = CLK_FREQ_HZ / DIGIT_HZ;
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // The drive phase must be non-empty and the blank phase must exist.
  if (PRESCALE <= BLANK_CYCLES || BLANK_CYCLES < 1) begin : g_bad_timing
    $error("seg7_scan_ctrl: need 1 <= BLANK_CYCLES < CLK_FREQ_HZ/DIGIT_HZ");
  end

  // Index and buffer widths are tied to the eight-digit board.
  if (NUM_DIGITS != 8) begin : g_bad_digits
    $error("seg7_scan_ctrl: NUM_DIGITS must be 8");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  logic [31:0] sh_value_q, sh_value_d;
  logic [7:0]  sh_dp_q, sh_dp_d;
  logic [7:0]  sh_en_q, sh_en_d;
  logic        sh_lzb_q, sh_lzb_d;

  logic [31:0] dsp_value_q, dsp_value_d;
  logic [7:0]  dsp_dp_q, dsp_dp_d;
  logic [7:0]  dsp_en_q, dsp_en_d;
  logic        dsp_lzb_q, dsp_lzb_d;

  logic        pending_q, pending_d;

  logic [7:0]  an_q, an_d;
  seg_t        seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        slot_end;
  logic        frame_end;
  logic [7:0]  lz_mask;
  logic [3:0]  cur_nib;
  seg_t        cur_seg;
  logic        suppressed;
  logic        in_blank;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == 3'd7);

  // Prescaler and digit index; the index steps once per slot and wraps mod 8.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Shadow capture and frame-boundary swap. A load on the boundary cycle
  // wins: it refreshes the shadow and keeps the swap for the next frame.
  always_comb begin
    sh_value_d  = sh_value_q;
    sh_dp_d     = sh_dp_q;
    sh_en_d     = sh_en_q;
    sh_lzb_d    = sh_lzb_q;
    dsp_value_d = dsp_value_q;
    dsp_dp_d    = dsp_dp_q;
    dsp_en_d    = dsp_en_q;
    dsp_lzb_d   = dsp_lzb_q;
    pending_d   = pending_q;
    if (i_load) begin
      sh_value_d = i_value;
      sh_dp_d    = i_dp;
      sh_en_d    = i_en;
      sh_lzb_d   = i_lzb;
      pending_d  = 1'b1;
    end else if (frame_end && pending_q) begin
      dsp_value_d = sh_value_q;
      dsp_dp_d    = sh_dp_q;
      dsp_en_d    = sh_en_q;
      dsp_lzb_d   = sh_lzb_q;
      pending_d   = 1'b0;
    end
  end

  // Leading-zero mask: digit k is a leading zero when it and every higher
  // nibble are zero. Digit 0 always shows so a zero value reads "0".
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (dsp_value_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  assign cur_nib = dsp_value_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

  assign suppressed = !dsp_en_q[idx_q] || (dsp_lzb_q && lz_mask[idx_q]);
  assign in_blank   = (cnt_q < CNT_BLANK);

  // Pin values for the current slot phase; registered below so the pins
  // lag the count/index state by one cycle and never glitch.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!in_blank && !suppressed) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = cur_seg;
      dp_d  = ~dsp_dp_q[idx_q];
    end
  end

  // State and pin registers; reset darkens the display asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_value_q  <= '0;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
      sh_lzb_q    <= 1'b0;
      dsp_value_q <= '0;
      dsp_dp_q    <= '0;
      dsp_en_q    <= '0;
      dsp_lzb_q   <= 1'b0;
      pending_q   <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_value_q  <= sh_value_d;
      sh_dp_q     <= sh_dp_d;
      sh_en_q     <= sh_en_d;
      sh_lzb_q    <= sh_lzb_d;
      dsp_value_q <= dsp_value_d;
      dsp_dp_q    <= dsp_dp_d;
      dsp_en_q    <= dsp_en_d;
      dsp_lzb_q   <= dsp_lzb_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign o_pending    = pending_q;
  assign o_frame_tick = frame_end;
  assign o_an         = an_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with PRESCALE = 10, BLANK_CYCLES = 2.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rstn;
  logic [31:0] i_value;
  logic [7:0]  i_dp;
  logic [7:0]  i_en;
  logic        i_lzb;
  logic        i_load;
  logic        o_pending;
  logic        o_frame_tick;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int vec  = 0;
  int miss = 0;

  // One captured frame: {an, seg, dp} per cycle, index = count + 10*digit.
  logic [15:0] cap [80];
  // Hand-computed drive-phase value per digit; 16'hFFFF means dark.
  logic [15:0] exp_dig [8];

  seg7_scan_ctrl #(
    .CLK_FREQ_HZ  (1000),
    .DIGIT_HZ     (100),
    .BLANK_CYCLES (2),
    .NUM_DIGITS   (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_value      (i_value),
    .i_dp         (i_dp),
    .i_en         (i_en),
    .i_lzb        (i_lzb),
    .i_load       (i_load),
    .o_pending    (o_pending),
    .o_frame_tick (o_frame_tick),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_dp         (o_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp,
                         input logic [7:0] en, input logic lzb);
    i_value = v;
    i_dp    = dp;
    i_en    = en;
    i_lzb   = lzb;
    i_load  = 1'b1;
    step();
    i_load  = 1'b0;
  endtask

  // Returns at the negedge of the frame-boundary cycle.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (o_frame_tick === 1'b1) seen = 1'b1;
      else step();
    end
    vec++;
    if (!seen) begin
      miss++;
      $display("FAIL frame_tick_wait: got no pulse in 200 cycles, required one");
    end
  endtask

  // Call with the DUT at count 0 of a frame; cap[j] reflects state j.
  task automatic capture_frame();
    for (int j = 0; j < 80; j++) begin
      step();
      cap[j] = {o_an, o_seg, o_dp};
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_value = '0; i_dp = '0; i_en = '0; i_lzb = 1'b0; i_load = 1'b0;
    repeat (3) step();
    vec++; if (o_an !== 8'hFF) begin miss++; $display("FAIL reset_an: got %h required ff", o_an); end
    vec++; if (o_seg !== 7'h7F) begin miss++; $display("FAIL reset_seg: got %b required 1111111", o_seg); end
    vec++; if (o_dp !== 1'b1) begin miss++; $display("FAIL reset_dp: got %b required 1", o_dp); end
    vec++; if (o_pending !== 1'b0) begin miss++; $display("FAIL reset_pending: got %b required 0", o_pending); end
    vec++; if (o_frame_tick !== 1'b0) begin miss++; $display("FAIL reset_tick: got %b required 0", o_frame_tick); end
    rstn = 1'b1;
    step();
    vec++; if (o_an !== 8'hFF) begin miss++; $display("FAIL post_reset_an: got %h required ff", o_an); end
    vec++; if (o_pending !== 1'b0) begin miss++; $display("FAIL post_reset_pending: got %b required 0", o_pending); end
  endtask

  task automatic test_lzb();
    logic [15:0] e;
    do_load(32'h0000_1234, 8'h00, 8'hFF, 1'b1);
    vec++; if (o_pending !== 1'b1) begin miss++; $display("FAIL lzb_pending_set: got %b required 1", o_pending); end
    wait_tick();
    vec++; if (o_pending !== 1'b1) begin miss++; $display("FAIL lzb_pending_at_tick: got %b required 1", o_pending); end
    step();
    vec++; if (o_pending !== 1'b0) begin miss++; $display("FAIL lzb_pending_clear: got %b required 0", o_pending); end
    vec++; if (o_frame_tick !== 1'b0) begin miss++; $display("FAIL lzb_tick_width: got %b required 0", o_frame_tick); end
    capture_frame();
    exp_dig[0] = {8'hFE, 7'b1001100, 1'b1};
    exp_dig[1] = {8'hFD, 7'b0000110, 1'b1};
    exp_dig[2] = {8'hFB, 7'b0010010, 1'b1};
    exp_dig[3] = {8'hF7, 7'b1001111, 1'b1};
    for (int d = 4; d < 8; d++) exp_dig[d] = 16'hFFFF;
    for (int j = 0; j < 80; j++) begin
      e = ((j % 10) < 2) ? 16'hFFFF : exp_dig[j / 10];
      vec++;
      if (cap[j] !== e) begin
        miss++;
        $display("FAIL lzb_frame[%0d]: got %h required %h", j, cap[j], e);
      end
    end
  endtask

  task automatic test_no_lzb();
    logic [15:0] e;
    do_load(32'h0000_1234, 8'h00, 8'hFF, 1'b0);
    wait_tick();
    step();
    capture_frame();
    exp_dig[0] = {8'hFE, 7'b1001100, 1'b1};
    exp_dig[1] = {8'hFD, 7'b0000110, 1'b1};
    exp_dig[2] = {8'hFB, 7'b0010010, 1'b1};
    exp_dig[3] = {8'hF7, 7'b1001111, 1'b1};
    exp_dig[4] = {8'hEF, 7'b0000001, 1'b1};
    exp_dig[5] = {8'hDF, 7'b0000001, 1'b1};
    exp_dig[6] = {8'hBF, 7'b0000001, 1'b1};
    exp_dig[7] = {8'h7F, 7'b0000001, 1'b1};
    for (int j = 0; j < 80; j++) begin
      e = ((j % 10) < 2) ? 16'hFFFF : exp_dig[j / 10];
      vec++;
      if (cap[j] !== e) begin
        miss++;
        $display("FAIL nolzb_frame[%0d]: got %h required %h", j, cap[j], e);
      end
    end
  endtask

  task automatic test_last_load_wins();
    logic [15:0] e;
    int eights;
    do_load(32'h0000_0008, 8'h00, 8'hFF, 1'b1);
    do_load(32'h0000_000F, 8'h00, 8'hFF, 1'b1);
    wait_tick();
    step();
    capture_frame();
    exp_dig[0] = {8'hFE, 7'b0111000, 1'b1};
    for (int d = 1; d < 8; d++) exp_dig[d] = 16'hFFFF;
    eights = 0;
    for (int j = 0; j < 80; j++) begin
      e = ((j % 10) < 2) ? 16'hFFFF : exp_dig[j / 10];
      if (cap[j][7:1] == 7'b0000000) eights++;
      vec++;
      if (cap[j] !== e) begin
        miss++;
        $display("FAIL lastload_frame[%0d]: got %h required %h", j, cap[j], e);
      end
    end
    vec++;
    if (eights != 0) begin miss++; $display("FAIL lastload_no8: got %0d samples of 8, required 0", eights); end
  endtask

  task automatic test_back_to_back_tick_load();
    logic [15:0] e;
    wait_tick();
    i_value = 32'h0000_0005; i_dp = 8'h00; i_en = 8'hFF; i_lzb = 1'b1; i_load = 1'b1;
    step();
    i_load = 1'b0;
    vec++; if (o_pending !== 1'b1) begin miss++; $display("FAIL tickload_pending: got %b required 1", o_pending); end
    capture_frame();
    exp_dig[0] = {8'hFE, 7'b0111000, 1'b1};
    for (int d = 1; d < 8; d++) exp_dig[d] = 16'hFFFF;
    for (int j = 0; j < 80; j++) begin
      e = ((j % 10) < 2) ? 16'hFFFF : exp_dig[j / 10];
      vec++;
      if (cap[j] !== e) begin
        miss++;
        $display("FAIL tickload_old_frame[%0d]: got %h required %h", j, cap[j], e);
      end
    end
    vec++; if (o_pending !== 1'b0) begin miss++; $display("FAIL tickload_pending_clear: got %b required 0", o_pending); end
    capture_frame();
    exp_dig[0] = {8'hFE, 7'b0100100, 1'b1};
    for (int j = 0; j < 80; j++) begin
      e = ((j % 10) < 2) ? 16'hFFFF : exp_dig[j / 10];
      vec++;
      if (cap[j] !== e) begin
        miss++;
        $display("FAIL tickload_new_frame[%0d]: got %h required %h", j, cap[j], e);
      end
    end
  endtask

  task automatic test_enable_dp();
    logic [15:0] e;
    do_load(32'h0000_0000, 8'h01, 8'h01, 1'b0);
    wait_tick();
    step();
    capture_frame();
    exp_dig[0] = {8'hFE, 7'b0000001, 1'b0};
    for (int d = 1; d < 8; d++) exp_dig[d] = 16'hFFFF;
    for (int j = 0; j < 80; j++) begin
      e = ((j % 10) < 2) ? 16'hFFFF : exp_dig[j / 10];
      vec++;
      if (cap[j] !== e) begin
        miss++;
        $display("FAIL endp_frame[%0d]: got %h required %h", j, cap[j], e);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_load(32'h0000_0005, 8'h00, 8'hFF, 1'b0);
    vec++; if (o_pending !== 1'b1) begin miss++; $display("FAIL arst_pending_pre: got %b required 1", o_pending); end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (o_an !== 8'hFF) found = 1'b1;
      else step();
    end
    vec++;
    if (!found) begin miss++; $display("FAIL arst_find_drive: got no lit digit in 100 cycles, required one"); end
    #2;
    rstn = 1'b0;
    #1;
    vec++; if (o_an !== 8'hFF) begin miss++; $display("FAIL arst_an: got %h required ff", o_an); end
    vec++; if (o_seg !== 7'h7F) begin miss++; $display("FAIL arst_seg: got %b required 1111111", o_seg); end
    vec++; if (o_dp !== 1'b1) begin miss++; $display("FAIL arst_dp: got %b required 1", o_dp); end
    vec++; if (o_pending !== 1'b0) begin miss++; $display("FAIL arst_pending: got %b required 0", o_pending); end
    @(negedge clk);
    rstn = 1'b1;
    capture_frame();
    for (int j = 0; j < 80; j++) begin
      vec++;
      if (cap[j] !== 16'hFFFF) begin
        miss++;
        $display("FAIL arst_dark_frame[%0d]: got %h required ffff", j, cap[j]);
      end
    end
    vec++; if (o_pending !== 1'b0) begin miss++; $display("FAIL arst_pending_lost: got %b required 0", o_pending); end
  endtask

  initial begin
    test_reset();
    test_lzb();
    test_no_lzb();
    test_last_load_wins();
    test_back_to_back_tick_load();
    test_enable_dp();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
